// File: rtl/det_nxn_seq_pkg.sv
// det_pkg: shared types and helpers for the sequential NxN determinant engine.
//   state_t  : controller states
//   mac_op_t : multiply-accumulate operation selected per step
//   dst_t    : register that captures the MAC result in a given step
//   det_ow() : exact result width for 3x3 determinants of w-bit elements
//   elem()   : flat element index of (r,c) inside the packed matrix bus
package det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAC_LOAD = 2'd0,
        MAC_ADD  = 2'd1,
        MAC_SUB  = 2'd2
    } mac_op_t;

    typedef enum logic [1:0] {
        DST_MINOR = 2'd0,
        DST_ACC   = 2'd1,
        DST_DET   = 2'd2
    } dst_t;

    localparam int unsigned STEPS_3X3 = 9;
    localparam int unsigned STEPS_2X2 = 2;

    function automatic int det_ow(input int w);
        return 3 * w + 3;
    endfunction

    function automatic int unsigned elem(input int unsigned r, input int unsigned c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/det_nxn_seq_mac.sv
// det_mac: combinational signed multiply with load/add/sub of an accumulator operand.
//   a  in  2W+1  signed multiplicand (minor or sign-extended element)
//   b  in  W     signed element
//   c  in  OW    signed accumulator operand
//   op in  2     MAC_LOAD: y=a*b, MAC_ADD: y=c+a*b, MAC_SUB: y=c-a*b
//   y  out OW    signed result
module det_mac
    import det_pkg::*;
#(
    parameter int W  = 8,
    parameter int OW = 3 * W + 3
) (
    input  logic signed [2*W:0]  a,
    input  logic signed [W-1:0]  b,
    input  logic signed [OW-1:0] c,
    input  mac_op_t              op,
    output logic signed [OW-1:0] y
);

    logic signed [OW-1:0] prod;

    always_comb begin
        // Both operands sign-extended to the full result width; the product always fits.
        prod = OW'(a) * OW'(b);
        y    = prod;
        unique case (op)
            MAC_LOAD: y = prod;
            MAC_ADD:  y = c + prod;
            MAC_SUB:  y = c - prod;
            default:  y = prod;
        endcase
    end

endmodule

// File: rtl/det_nxn_seq.sv
// det_nxn_seq: sequential signed determinant of a 2x2 or 3x3 matrix, one shared
// multiplier, cofactor expansion along row 0.
//   clk       in   1     rising-edge clock
//   rst       in   1     synchronous active-high reset
//   in_valid  in   1     matrix and mode present
//   in_ready  out  1     engine idle and able to accept
//   mode      in   1     0 = 3x3, 1 = 2x2 (top-left of mat_in)
//   mat_in    in   9*W   element (r,c) at bits [(3r+c)*W +: W], signed
//   out_valid out  1     det valid, held until out_ready
//   out_ready in   1     consumer takes det
//   det       out  OW    signed determinant
module det_nxn_seq
    import det_pkg::*;
#(
    parameter  int W  = 8,
    localparam int OW = det_ow(W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [9*W-1:0]       mat_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] det
);

    localparam int MW = 2 * W + 1;

    localparam int unsigned A00 = elem(0, 0);
    localparam int unsigned A01 = elem(0, 1);
    localparam int unsigned A02 = elem(0, 2);
    localparam int unsigned A10 = elem(1, 0);
    localparam int unsigned A11 = elem(1, 1);
    localparam int unsigned A12 = elem(1, 2);
    localparam int unsigned A20 = elem(2, 0);
    localparam int unsigned A21 = elem(2, 1);
    localparam int unsigned A22 = elem(2, 2);

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           step;
    logic [9*W-1:0]       mat_r;
    logic                 mode_r;
    logic signed [MW-1:0] minor;
    logic signed [OW-1:0] acc;
    logic                 accept;
    logic                 last_step;

    logic signed [W-1:0]  e [9];

    logic signed [MW-1:0] mac_a;
    logic signed [W-1:0]  mac_b;
    logic signed [OW-1:0] mac_c;
    mac_op_t              mac_op;
    logic signed [OW-1:0] mac_y;
    dst_t                 dst;

    for (genvar g = 0; g < 9; g++) begin : g_elem
        assign e[g] = mat_r[g*W +: W];
    end

    // Step decoder: operands, operation and destination for the current CALC step.
    always_comb begin
        mac_a  = '0;
        mac_b  = '0;
        mac_c  = '0;
        mac_op = MAC_LOAD;
        dst    = DST_MINOR;
        if (mode_r) begin
            unique case (step)
                4'd0: begin
                    mac_a = MW'(e[A00]); mac_b = e[A11];
                    mac_op = MAC_LOAD; dst = DST_ACC;
                end
                4'd1: begin
                    mac_a = MW'(e[A01]); mac_b = e[A10]; mac_c = acc;
                    mac_op = MAC_SUB; dst = DST_DET;
                end
                default: ;
            endcase
        end else begin
            unique case (step)
                4'd0: begin
                    mac_a = MW'(e[A11]); mac_b = e[A22];
                    mac_op = MAC_LOAD; dst = DST_MINOR;
                end
                4'd1: begin
                    mac_a = MW'(e[A12]); mac_b = e[A21]; mac_c = OW'(minor);
                    mac_op = MAC_SUB; dst = DST_MINOR;
                end
                4'd2: begin
                    mac_a = minor; mac_b = e[A00];
                    mac_op = MAC_LOAD; dst = DST_ACC;
                end
                4'd3: begin
                    mac_a = MW'(e[A10]); mac_b = e[A22];
                    mac_op = MAC_LOAD; dst = DST_MINOR;
                end
                4'd4: begin
                    mac_a = MW'(e[A12]); mac_b = e[A20]; mac_c = OW'(minor);
                    mac_op = MAC_SUB; dst = DST_MINOR;
                end
                4'd5: begin
                    mac_a = minor; mac_b = e[A01]; mac_c = acc;
                    mac_op = MAC_SUB; dst = DST_ACC;
                end
                4'd6: begin
                    mac_a = MW'(e[A10]); mac_b = e[A21];
                    mac_op = MAC_LOAD; dst = DST_MINOR;
                end
                4'd7: begin
                    mac_a = MW'(e[A11]); mac_b = e[A20]; mac_c = OW'(minor);
                    mac_op = MAC_SUB; dst = DST_MINOR;
                end
                4'd8: begin
                    mac_a = minor; mac_b = e[A02]; mac_c = acc;
                    mac_op = MAC_ADD; dst = DST_DET;
                end
                default: ;
            endcase
        end
    end

    det_mac #(
        .W  (W),
        .OW (OW)
    ) u_mac (
        .a  (mac_a),
        .b  (mac_b),
        .c  (mac_c),
        .op (mac_op),
        .y  (mac_y)
    );

    always_comb begin
        last_step = mode_r ? (step == 4'(STEPS_2X2 - 1)) : (step == 4'(STEPS_3X3 - 1));
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mat_r  <= '0;
            mode_r <= 1'b0;
            step   <= '0;
            minor  <= '0;
            acc    <= '0;
            det    <= '0;
        end else if (accept) begin
            mat_r  <= mat_in;
            mode_r <= mode;
            step   <= '0;
        end else if (state == CALC) begin
            step <= step + 4'd1;
            unique case (dst)
                DST_MINOR: minor <= mac_y[MW-1:0];
                DST_ACC:   acc   <= mac_y;
                DST_DET:   det   <= mac_y;
                default:   ;
            endcase
        end
    end

endmodule
